cpu_out_uart: RTL and testbench

CPU_OUT_UART -- requirements
Module: cpu_out_uart

---
 rtl/cpu_out_uart.sv | 162 ++++++++++++++++
 tb/tb_cpu_out_uart.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_out_uart.sv
// CPU output port: byte FIFO feeding an 8N1 serial transmitter.
// Writes never stall; bytes arriving while the FIFO is full are dropped.
module cpu_out_uart #(
  parameter int DEPTH        = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic [7:0]               out_data,
  input  logic                     out_we,
  output logic                     tx,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [BW-1:0] BIT_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    shift_q, shift_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic          tx_q, tx_d;
  logic          pop;
  logic          push;

  // Serializer next state: pop from IDLE, then start, 8 data bits, stop.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (count_q != '0) begin
          pop       = 1'b1;
          shift_d   = mem_q[rd_ptr_q];
          state_d   = START;
          bit_cnt_d = BIT_LAST;
          tx_d      = 1'b0;
        end
      end
      START: begin
        if (bit_cnt_q == '0) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
          bit_cnt_d = BIT_LAST;
          tx_d      = shift_q[0];
        end else begin
          bit_cnt_d = bit_cnt_q - 1'b1;
        end
      end
      DATA: begin
        if (bit_cnt_q == '0) begin
          bit_cnt_d = BIT_LAST;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          bit_cnt_d = bit_cnt_q - 1'b1;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (bit_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          bit_cnt_d = bit_cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // FIFO bookkeeping: a full FIFO still accepts a write when it pops too.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    push     = out_we && ((count_q != DEPTH_C) || pop);
    ovf_d    = ovf_q || (out_we && !push);
    if (push) begin
      mem_d[wr_ptr_q] = out_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // State registers; reset aborts any frame and discards buffered bytes.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      mem_q     <= '{default: '0};
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = (state_q != IDLE);
  assign count    = count_q;
  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign overflow = ovf_q;

endmodule

// File: tb/tb_cpu_out_uart.sv
// Bench for cpu_out_uart: directed steps, byte scoreboard,
// and a line monitor that checks every frame cycle by cycle.
module tb_cpu_out_uart;

  logic       CLK;
  logic       reset;
  logic [7:0] out_data;
  logic       out_we;
  logic       tx;
  logic       busy;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic       overflow;

  cpu_out_uart #(
    .DEPTH(4),
    .CLKS_PER_BIT(4)
  ) dut (
    .CLK(CLK),
    .reset(reset),
    .out_data(out_data),
    .out_we(out_we),
    .tx(tx),
    .busy(busy),
    .count(count),
    .full(full),
    .empty(empty),
    .overflow(overflow)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [7:0] sb[$];

  int frames_done = 0;
  int frm_start [64];
  int frm_zeros [64];

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line monitor: capture 40 cycles from the start bit, compare to
  // the frame the scoreboard says must come next.
  initial begin
    logic [39:0] vec;
    logic [39:0] exp;
    logic [7:0]  b;
    int          n;
    int          st;
    int          z;
    bit          act;
    act = 0;
    n   = 0;
    st  = 0;
    vec = '0;
    forever begin
      @(negedge CLK);
      if (reset) begin
        act = 0;
        n   = 0;
      end else if (!act) begin
        if (tx === 1'b0) begin
          act    = 1;
          vec    = '0;
          vec[0] = 1'b0;
          n      = 1;
          st     = cyc;
        end
      end else begin
        vec[n] = tx;
        n++;
        if (n == 40) begin
          if (sb.size() == 0) begin
            chk("frame_expected", 64'(0), 64'(1));
          end else begin
            b = sb.pop_front();
            for (int k = 0; k < 40; k++) begin
              if (k < 4)       exp[k] = 1'b0;
              else if (k < 36) exp[k] = b[(k - 4) / 4];
              else             exp[k] = 1'b1;
            end
            chk("frame_wave", 64'(vec), 64'(exp));
          end
          z = 0;
          for (int k = 0; k < 40; k++) if (vec[k] == 1'b0) z++;
          frm_start[frames_done] = st;
          frm_zeros[frames_done] = z;
          frames_done++;
          act = 0;
        end
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic wait_frames(input string tag, input int target,
                             input int max);
    int k;
    k = 0;
    while (frames_done < target && k < max) begin
      @(negedge CLK);
      k++;
    end
    chk(tag, 64'(frames_done), 64'(target));
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    reset = 1'b1;
    repeat (2) @(negedge CLK);
    sb.delete();
    reset = 1'b0;
  endtask

  initial begin
    int n;
    int f0;
    int lows;
    int bz;
    int expc [6];
    expc = '{1, 1, 2, 3, 4, 4};

    reset    = 1'b1;
    out_we   = 1'b0;
    out_data = 8'h00;

    // reset state
    #20;
    chk("rst_tx", 64'(tx), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_empty", 64'(empty), 64'(1));
    chk("rst_full", 64'(full), 64'(0));
    chk("rst_ovf", 64'(overflow), 64'(0));
    @(negedge CLK);
    reset = 1'b0;

    // single byte 0xA5
    sb.push_back(8'hA5);
    f0 = frames_done;
    @(negedge CLK);
    out_data = 8'hA5;
    out_we   = 1'b1;
    @(posedge CLK);
    #1;
    chk("single_cnt_e0", 64'(count), 64'(1));
    chk("single_busy_e0", 64'(busy), 64'(0));
    @(negedge CLK);
    out_we = 1'b0;
    @(posedge CLK);
    #1;
    chk("single_busy_e1", 64'(busy), 64'(1));
    chk("single_tx_e1", 64'(tx), 64'(0));
    chk("single_cnt_e1", 64'(count), 64'(0));
    n = 0;
    @(negedge CLK);
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge CLK);
    end
    chk("single_busy_len", 64'(n), 64'(40));
    chk("single_empty", 64'(empty), 64'(1));
    wait_frames("single_frames", f0 + 1, 20);

    // burst of 6 into depth 4
    f0 = frames_done;
    for (int i = 1; i <= 5; i++) sb.push_back(8'(i));
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      out_data = 8'(i + 1);
      out_we   = 1'b1;
      @(posedge CLK);
      #1;
      chk("burst_cnt", 64'(count), 64'(expc[i]));
      if (i == 1) chk("burst_pop_e2", 64'(busy), 64'(1));
    end
    @(negedge CLK);
    out_we = 1'b0;
    chk("burst_ovf", 64'(overflow), 64'(1));
    chk("burst_full", 64'(full), 64'(1));
    wait_frames("burst_frames", f0 + 5, 300);
    for (int i = 0; i < 4; i++)
      chk("burst_period",
          64'(frm_start[f0 + i + 1] - frm_start[f0 + i]), 64'(41));
    chk("burst_empty", 64'(empty), 64'(1));
    chk("burst_ovf_sticky", 64'(overflow), 64'(1));

    pulse_reset();
    chk("ovf_cleared", 64'(overflow), 64'(0));

    // full FIFO written on the exact pop cycle
    f0 = frames_done;
    for (int i = 0; i < 6; i++) sb.push_back(8'h50 + 8'(i));
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      out_data = 8'h50 + 8'(i);
      out_we   = 1'b1;
      @(posedge CLK);
    end
    @(negedge CLK);
    out_we = 1'b0;
    chk("fp_full_mid", 64'(count), 64'(4));
    n = 0;
    while (busy === 1'b1 && n < 60) begin
      @(negedge CLK);
      n++;
    end
    chk("fp_idle_full", 64'(full), 64'(1));
    out_data = 8'h55;
    out_we   = 1'b1;
    @(posedge CLK);
    #1;
    chk("fp_cnt", 64'(count), 64'(4));
    chk("fp_ovf", 64'(overflow), 64'(0));
    chk("fp_busy", 64'(busy), 64'(1));
    @(negedge CLK);
    out_we = 1'b0;
    wait_frames("fp_frames", f0 + 6, 400);
    chk("fp_ovf_end", 64'(overflow), 64'(0));

    // reset during data bit 3 of 0x3C, two bytes queued
    f0 = frames_done;
    sb.push_back(8'h3C);
    sb.push_back(8'h11);
    sb.push_back(8'h22);
    @(negedge CLK);
    out_data = 8'h3C;
    out_we   = 1'b1;
    @(negedge CLK);
    out_data = 8'h11;
    @(negedge CLK);
    out_data = 8'h22;
    @(negedge CLK);
    out_we = 1'b0;
    chk("mid_queued", 64'(count), 64'(2));
    repeat (16) @(posedge CLK);
    #3;
    chk("mid_busy_pre", 64'(busy), 64'(1));
    reset = 1'b1;
    #1;
    chk("mid_tx", 64'(tx), 64'(1));
    chk("mid_cnt", 64'(count), 64'(0));
    chk("mid_busy", 64'(busy), 64'(0));
    chk("mid_empty", 64'(empty), 64'(1));
    sb.delete();
    repeat (2) @(negedge CLK);
    reset = 1'b0;
    lows = 0;
    bz   = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (tx !== 1'b1) lows++;
      if (busy !== 1'b0) bz++;
    end
    chk("mid_no_tx", 64'(lows), 64'(0));
    chk("mid_no_busy", 64'(bz), 64'(0));
    chk("mid_no_frames", 64'(frames_done), 64'(f0));

    // extremes 0x00 and 0xFF
    f0 = frames_done;
    sb.push_back(8'h00);
    sb.push_back(8'hFF);
    @(negedge CLK);
    out_data = 8'h00;
    out_we   = 1'b1;
    @(negedge CLK);
    out_data = 8'hFF;
    @(negedge CLK);
    out_we = 1'b0;
    wait_frames("ext_frames", f0 + 2, 150);
    chk("ext_zero_low", 64'(frm_zeros[f0]), 64'(36));
    chk("ext_ff_low", 64'(frm_zeros[f0 + 1]), 64'(4));
    chk("ext_period",
        64'(frm_start[f0 + 1] - frm_start[f0]), 64'(41));

    repeat (5) @(negedge CLK);
    chk("sb_drained", 64'(sb.size()), 64'(0));
    chk("end_empty", 64'(empty), 64'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
